// File: rtl/vec_host_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : vec_host_sequencer_if
//  Description : Bundles the host command channel, the accelerator channel
//                and the result/status signals of vec_host_sequencer.
//                Signal names keep their direction suffix as seen from the
//                sequencer (_i = into the sequencer, _o = out of it).
//  Modports    : slave  - the sequencer itself
//                master - the environment (host + accelerator) around it
//  Ports       : cmd_*   host command (valid/ready, op, A/B/D addr, scalar,
//                        write data)
//                acc_*   accelerator request (valid/ready), completion,
//                        read data (r_v/yumi)
//                res_*   read result (valid/yumi)
//                busy_o, err_timeout_o, err_clear_i, cmd_count_o status
//  Revision    : 1.0  initial release
// ============================================================================
interface vec_host_sequencer_if #(
   parameter int els_p  = 16,
   parameter int vlen_p = 4,
   parameter int vdw_p  = 8
);
   localparam int c_AW = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int c_DW = vlen_p * vdw_p;

   // host command channel
   logic              cmd_v_i;
   logic              cmd_ready_o;
   logic [3:0]        cmd_op_i;
   logic [c_AW-1:0]   cmd_addrA_i;
   logic [c_AW-1:0]   cmd_addrB_i;
   logic [c_AW-1:0]   cmd_addrD_i;
   logic [vdw_p-1:0]  cmd_scalar_i;
   logic [c_DW-1:0]   cmd_data_i;

   // accelerator channel
   logic [3:0]        acc_op_o;
   logic [c_AW-1:0]   acc_addrA_o;
   logic [c_AW-1:0]   acc_addrB_o;
   logic [c_AW-1:0]   acc_addrD_o;
   logic [vdw_p-1:0]  acc_scalar_o;
   logic [c_DW-1:0]   acc_w_data_o;
   logic              acc_v_o;
   logic              acc_ready_i;
   logic              acc_done_i;
   logic [c_DW-1:0]   acc_r_data_i;
   logic              acc_r_v_i;
   logic              acc_yumi_o;

   // result and status
   logic              res_v_o;
   logic [c_DW-1:0]   res_data_o;
   logic              res_yumi_i;
   logic              busy_o;
   logic              err_timeout_o;
   logic              err_clear_i;
   logic [15:0]       cmd_count_o;

   modport slave (
      input  cmd_v_i, cmd_op_i, cmd_addrA_i, cmd_addrB_i, cmd_addrD_i,
             cmd_scalar_i, cmd_data_i,
             acc_ready_i, acc_done_i, acc_r_data_i, acc_r_v_i,
             res_yumi_i, err_clear_i,
      output cmd_ready_o,
             acc_op_o, acc_addrA_o, acc_addrB_o, acc_addrD_o, acc_scalar_o,
             acc_w_data_o, acc_v_o, acc_yumi_o,
             res_v_o, res_data_o, busy_o, err_timeout_o, cmd_count_o
   );

   modport master (
      output cmd_v_i, cmd_op_i, cmd_addrA_i, cmd_addrB_i, cmd_addrD_i,
             cmd_scalar_i, cmd_data_i,
             acc_ready_i, acc_done_i, acc_r_data_i, acc_r_v_i,
             res_yumi_i, err_clear_i,
      input  cmd_ready_o,
             acc_op_o, acc_addrA_o, acc_addrB_o, acc_addrD_o, acc_scalar_o,
             acc_w_data_o, acc_v_o, acc_yumi_o,
             res_v_o, res_data_o, busy_o, err_timeout_o, cmd_count_o
   );
endinterface
`default_nettype wire

// File: rtl/vec_host_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : vec_host_sequencer
//  Description : Accepts one vector command at a time from a host, issues it
//                to a vector accelerator, waits for completion (with a
//                timeout), and for read commands presents the returned
//                vector to the host until it is consumed.
//  Ports       : clk_i      clock
//                reset_n_i  asynchronous active-low reset
//                bus        vec_host_sequencer_if.slave (command, accelerator,
//                           result and status signals)
//  Revision    : 1.0  initial release
// ============================================================================
module vec_host_sequencer #(
   parameter int els_p     = 16,
   parameter int vlen_p    = 4,
   parameter int vdw_p     = 8,
   parameter int timeout_p = 1024
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   vec_host_sequencer_if.slave  bus
);

   localparam int c_AW = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int c_DW = vlen_p * vdw_p;
   localparam int c_TW = (timeout_p > 1) ? $clog2(timeout_p) : 1;

   // last WAIT cycle index before the command is abandoned
   localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(timeout_p - 1);
   localparam logic [3:0]      c_OP_READ = 4'b1000;

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_ISSUE = 2'd1;
   localparam logic [1:0] c_ST_WAIT  = 2'd2;
   localparam logic [1:0] c_ST_RESP  = 2'd3;

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   logic [1:0]        r_state;
   logic [3:0]        r_op;
   logic [c_AW-1:0]   r_addr_a;
   logic [c_AW-1:0]   r_addr_b;
   logic [c_AW-1:0]   r_addr_d;
   logic [vdw_p-1:0]  r_scalar;
   logic [c_DW-1:0]   r_wdata;
   logic [c_TW-1:0]   r_wait_cnt;
   logic [c_DW-1:0]   r_res_data;
   logic              r_err;
   logic [15:0]       r_cmd_count;

   // ---------------------------------------------------------------------
   // Combinational signals
   // ---------------------------------------------------------------------
   logic [1:0]  w_state_nxt;
   logic        w_is_read;
   logic        w_rd_ret;
   logic        w_complete;
   logic        w_timeout;
   logic        w_cmd_fire;
   logic        w_capture;
   logic        w_count_inc;
   logic        w_err_set;
   logic        w_cmd_ready;
   logic        w_busy;
   logic        w_acc_v;
   logic        w_acc_yumi;
   logic        w_res_v;

   assign w_is_read  = (r_op == c_OP_READ);
   // a read finishes only when done and returned data coincide
   assign w_rd_ret   = bus.acc_done_i & bus.acc_r_v_i;
   assign w_complete = w_is_read ? w_rd_ret : bus.acc_done_i;
   // completion on the last allowed cycle still counts as success
   assign w_timeout  = (r_wait_cnt == c_TO_LAST) & ~w_complete;

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (bus.cmd_v_i) begin
               w_state_nxt = c_ST_ISSUE;
            end
         end
         c_ST_ISSUE: begin
            if (bus.acc_ready_i) begin
               w_state_nxt = c_ST_WAIT;
            end
         end
         c_ST_WAIT: begin
            if (w_complete) begin
               w_state_nxt = w_is_read ? c_ST_RESP : c_ST_IDLE;
            end else if (w_timeout) begin
               w_state_nxt = c_ST_IDLE;
            end
         end
         c_ST_RESP: begin
            if (bus.res_yumi_i) begin
               w_state_nxt = c_ST_IDLE;
            end
         end
         default: w_state_nxt = c_ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs and datapath strobes
   // ---------------------------------------------------------------------
   always_comb begin
      w_cmd_ready = 1'b0;
      w_busy      = 1'b1;
      w_acc_v     = 1'b0;
      w_acc_yumi  = 1'b0;
      w_res_v     = 1'b0;
      w_cmd_fire  = 1'b0;
      w_capture   = 1'b0;
      w_count_inc = 1'b0;
      w_err_set   = 1'b0;
      case (r_state)
         c_ST_IDLE: begin
            w_cmd_ready = 1'b1;
            w_busy      = 1'b0;
            w_cmd_fire  = bus.cmd_v_i;
         end
         c_ST_ISSUE: begin
            w_acc_v = 1'b1;
         end
         c_ST_WAIT: begin
            w_acc_yumi  = w_is_read & w_rd_ret;
            w_capture   = w_is_read & w_rd_ret;
            w_count_inc = w_complete;
            w_err_set   = w_timeout;
         end
         c_ST_RESP: begin
            w_res_v = 1'b1;
         end
         default: begin
            w_busy = 1'b1;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Command field capture; held until the next accepted command so the
   // accelerator sees stable fields through ISSUE and WAIT.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_op     <= '0;
         r_addr_a <= '0;
         r_addr_b <= '0;
         r_addr_d <= '0;
         r_scalar <= '0;
         r_wdata  <= '0;
      end else if (w_cmd_fire) begin
         r_op     <= bus.cmd_op_i;
         r_addr_a <= bus.cmd_addrA_i;
         r_addr_b <= bus.cmd_addrB_i;
         r_addr_d <= bus.cmd_addrD_i;
         r_scalar <= bus.cmd_scalar_i;
         r_wdata  <= bus.cmd_data_i;
      end
   end

   // ---------------------------------------------------------------------
   // WAIT cycle counter: held at zero in ISSUE so it starts from zero on
   // the first WAIT cycle; WAIT is always left by the time it reaches
   // c_TO_LAST, so it never wraps.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_wait_cnt <= '0;
      end else if (r_state == c_ST_WAIT) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
         r_wait_cnt <= '0;
      end
   end

   // ---------------------------------------------------------------------
   // Result data, sticky timeout flag (set beats clear), completion count
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_res_data  <= '0;
         r_err       <= 1'b0;
         r_cmd_count <= '0;
      end else begin
         if (w_capture) begin
            r_res_data <= bus.acc_r_data_i;
         end
         if (w_err_set) begin
            r_err <= 1'b1;
         end else if (bus.err_clear_i) begin
            r_err <= 1'b0;
         end
         if (w_count_inc) begin
            r_cmd_count <= r_cmd_count + 16'd1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Output drive
   // ---------------------------------------------------------------------
   assign bus.cmd_ready_o   = w_cmd_ready;
   assign bus.busy_o        = w_busy;
   assign bus.acc_v_o       = w_acc_v;
   assign bus.acc_yumi_o    = w_acc_yumi;
   assign bus.res_v_o       = w_res_v;
   assign bus.acc_op_o      = r_op;
   assign bus.acc_addrA_o   = r_addr_a;
   assign bus.acc_addrB_o   = r_addr_b;
   assign bus.acc_addrD_o   = r_addr_d;
   assign bus.acc_scalar_o  = r_scalar;
   assign bus.acc_w_data_o  = r_wdata;
   assign bus.res_data_o    = r_res_data;
   assign bus.err_timeout_o = r_err;
   assign bus.cmd_count_o   = r_cmd_count;

endmodule
`default_nettype wire

// File: tb/tb_vec_host_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vec_host_sequencer
//  Description : Self-checking bench for vec_host_sequencer. Directed
//                scenarios followed by randomized commands; expectations
//                come from a transaction-level model of the command rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vec_host_sequencer;

   localparam int c_TO = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int checks   = 0;
   int failures = 0;

   // transaction-level model state
   int unsigned m_count = 0;
   logic [31:0] m_res   = '0;
   bit          m_err   = 1'b0;

   vec_host_sequencer_if #(.els_p(16), .vlen_p(4), .vdw_p(8)) bus ();

   vec_host_sequencer #(
      .els_p     (16),
      .vlen_p    (4),
      .vdw_p     (8),
      .timeout_p (c_TO)
   ) dut (
      .clk_i     (clk),
      .reset_n_i (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] acc_fields();
      return {8'h0, bus.acc_op_o, bus.acc_addrA_o, bus.acc_addrB_o, bus.acc_addrD_o,
              bus.acc_scalar_o, bus.acc_w_data_o};
   endfunction

   task automatic check_idle(input string tag);
      check({tag, ".cmd_ready"}, bus.cmd_ready_o, 1);
      check({tag, ".busy"},      bus.busy_o, 0);
      check({tag, ".acc_v"},     bus.acc_v_o, 0);
      check({tag, ".res_v"},     bus.res_v_o, 0);
      check({tag, ".count"},     bus.cmd_count_o, m_count[15:0]);
      check({tag, ".err"},       bus.err_timeout_o, m_err);
      check({tag, ".res_data"},  bus.res_data_o, m_res);
   endtask

   // One full command, entered and left at a negedge with the DUT idle.
   task automatic run_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] d, input logic [7:0] sc, input logic [31:0] wd,
                          input logic [31:0] rd, input int rdy_dly, input int done_dly,
                          input int rv_extra, input int resp_dly, input bit clr_in_wait,
                          input bit junk_cmd);
      bit          is_rd;
      int          comp;
      bit          tmo;
      logic [63:0] exp_f;
      is_rd = (op == 4'b1000);
      comp  = is_rd ? done_dly + rv_extra : done_dly;
      tmo   = (comp >= c_TO);
      exp_f = {8'h0, op, a, b, d, sc, wd};

      check_idle("pre");
      bus.cmd_v_i      = 1'b1;
      bus.cmd_op_i     = op;
      bus.cmd_addrA_i  = a;
      bus.cmd_addrB_i  = b;
      bus.cmd_addrD_i  = d;
      bus.cmd_scalar_i = sc;
      bus.cmd_data_i   = wd;
      @(negedge clk);

      // ISSUE: a second command on cmd_v_i must be ignored
      bus.cmd_v_i = junk_cmd;
      if (junk_cmd) begin
         bus.cmd_op_i     = ~op;
         bus.cmd_addrA_i  = ~a;
         bus.cmd_addrD_i  = ~d;
         bus.cmd_data_i   = ~wd;
      end
      for (int i = 0; i <= rdy_dly; i++) begin
         bus.acc_ready_i = (i == rdy_dly);
         bus.acc_done_i  = 1'($urandom);
         bus.acc_r_v_i   = 1'($urandom);
         #1;
         check("issue.acc_v",     bus.acc_v_o, 1);
         check("issue.cmd_ready", bus.cmd_ready_o, 0);
         check("issue.busy",      bus.busy_o, 1);
         check("issue.yumi",      bus.acc_yumi_o, 0);
         check("issue.fields",    acc_fields(), exp_f);
         @(negedge clk);
      end
      bus.cmd_v_i = 1'b0;

      // WAIT
      for (int w = 0; w < c_TO; w++) begin
         bus.acc_ready_i = 1'($urandom);
         if (is_rd) begin
            bus.acc_done_i = (w >= done_dly);
            bus.acc_r_v_i  = (w >= comp) || ((w < done_dly) && 1'($urandom));
         end else begin
            bus.acc_done_i = (w == done_dly);
            bus.acc_r_v_i  = 1'($urandom);
         end
         bus.acc_r_data_i = (w == comp) ? rd : $urandom;
         bus.err_clear_i  = clr_in_wait;
         #1;
         check("wait.yumi",   bus.acc_yumi_o, (is_rd && w == comp) ? 1 : 0);
         check("wait.acc_v",  bus.acc_v_o, 0);
         check("wait.busy",   bus.busy_o, 1);
         check("wait.res_v",  bus.res_v_o, 0);
         check("wait.fields", acc_fields(), exp_f);
         @(negedge clk);
         if (w == comp) break;
      end
      bus.acc_ready_i = 1'b0;
      bus.acc_done_i  = 1'b0;
      bus.acc_r_v_i   = 1'b0;
      bus.err_clear_i = 1'b0;

      if (tmo) begin
         m_err = 1'b1;
      end else begin
         if (clr_in_wait) m_err = 1'b0;
         m_count = (m_count + 1) & 32'hFFFF;
         if (is_rd) m_res = rd;
      end

      // RESP
      if (is_rd && !tmo) begin
         for (int i = 0; i <= resp_dly; i++) begin
            bus.res_yumi_i  = (i == resp_dly);
            bus.acc_done_i  = 1'($urandom);
            bus.acc_r_v_i   = 1'($urandom);
            #1;
            check("resp.res_v",     bus.res_v_o, 1);
            check("resp.res_data",  bus.res_data_o, m_res);
            check("resp.cmd_ready", bus.cmd_ready_o, 0);
            check("resp.yumi",      bus.acc_yumi_o, 0);
            @(negedge clk);
         end
         bus.res_yumi_i = 1'b0;
         bus.acc_done_i = 1'b0;
         bus.acc_r_v_i  = 1'b0;
      end
      check_idle("post");
   endtask

   initial begin
      logic [3:0] rop;
      bus.cmd_v_i = 0; bus.cmd_op_i = 0; bus.cmd_addrA_i = 0; bus.cmd_addrB_i = 0;
      bus.cmd_addrD_i = 0; bus.cmd_scalar_i = 0; bus.cmd_data_i = 0;
      bus.acc_ready_i = 0; bus.acc_done_i = 0; bus.acc_r_data_i = 0; bus.acc_r_v_i = 0;
      bus.res_yumi_i = 0; bus.err_clear_i = 0;

      // reset state
      #1;
      check_idle("reset");
      check("reset.fields", acc_fields(), 64'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // write: op 1001, addrD 3, ready at once, done 4 WAIT cycles later
      run_cmd(4'b1001, 4'd0, 4'd0, 4'd3, 8'h00, 32'h01020201, 32'h0, 0, 4, 0, 0, 0, 0);
      // read: addrA 8, done before r_v (must stay in WAIT), result held 3 cycles
      run_cmd(4'b1000, 4'd8, 4'd0, 4'd0, 8'h00, 32'h0, 32'h080C0C0E, 0, 1, 2, 3, 0, 0);
      // backpressure: ready low 5 cycles, second command offered meanwhile
      run_cmd(4'b0110, 4'd1, 4'd2, 4'd5, 8'h5A, 32'hDEADBEEF, 32'h0, 5, 0, 0, 0, 0, 1);
      // timeout on mmul; clear held through WAIT loses to the set
      run_cmd(4'b1111, 4'd4, 4'd6, 4'd7, 8'h11, 32'h0, 32'h0, 0, 100, 0, 0, 1, 0);
      bus.err_clear_i = 1'b1;
      @(negedge clk);
      bus.err_clear_i = 1'b0;
      m_err = 1'b0;
      check_idle("errclr");

      // reset in the middle of WAIT, with err set and a read completing
      run_cmd(4'b1111, 4'd1, 4'd1, 4'd1, 8'h22, 32'h0, 32'h0, 0, 100, 0, 0, 0, 0);
      bus.cmd_v_i = 1'b1; bus.cmd_op_i = 4'b1000; bus.cmd_addrA_i = 4'd9;
      bus.cmd_scalar_i = 8'h77; bus.cmd_data_i = 32'hCAFEF00D;
      @(negedge clk);
      bus.cmd_v_i = 1'b0; bus.acc_ready_i = 1'b1;
      @(negedge clk);
      bus.acc_ready_i = 1'b0; bus.acc_done_i = 1'b1; bus.acc_r_v_i = 1'b1;
      bus.acc_r_data_i = 32'h12345678;
      #1;
      check("rst.pre_yumi", bus.acc_yumi_o, 1);
      #1 rst_n = 1'b0;
      #1;
      m_count = 0; m_res = '0; m_err = 1'b0;
      check("rst.yumi",   bus.acc_yumi_o, 0);
      check("rst.fields", acc_fields(), 64'h0);
      check_idle("rst");
      bus.acc_done_i = 1'b0; bus.acc_r_v_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("rst.after");
      run_cmd(4'b1000, 4'd2, 4'd0, 4'd0, 8'h00, 32'h0, 32'hA5A55A5A, 1, 2, 0, 1, 0, 0);

      // count wrap: preload the completion count to FFFF
      force dut.r_cmd_count = 16'hFFFF;
      @(negedge clk);
      release dut.r_cmd_count;
      m_count = 32'hFFFF;
      check("wrap.pre", bus.cmd_count_o, 16'hFFFF);
      run_cmd(4'b1001, 4'd0, 4'd0, 4'd9, 8'h01, 32'h0BADF00D, 32'h0, 0, 0, 0, 0, 0, 0);
      check("wrap.zero", bus.cmd_count_o, 16'h0000);

      // randomized commands
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 4))
            0:       rop = 4'b1000;
            1:       rop = 4'b1001;
            2:       rop = 4'b1111;
            3:       rop = {2'b00, 2'($urandom)};
            default: rop = {2'b01, 2'($urandom)};
         endcase
         run_cmd(rop, 4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom), $urandom,
                 $urandom, $urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(0, 2),
                 $urandom_range(0, 3), 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            bus.err_clear_i = 1'b1;
            @(negedge clk);
            bus.err_clear_i = 1'b0;
            m_err = 1'b0;
            check("rand.errclr", bus.err_timeout_o, 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
